// File: rtl/pool_stream_gen_if.sv
// Stream bundle for pool_stream_gen: a pixel input stream and a pooled-result output stream.
// A beat moves on a rising edge only when valid && ready; valid holds its data until that edge.
interface pool_stream_gen_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/pool_stream_gen.sv
// Streaming K x K non-overlapping max/average pooling over NUM_CH channel-major feature maps.
// Row partials live in a line buffer of IN_WIDTH/POOL_K accumulators.
module pool_stream_gen #(
   parameter int DATA_WIDTH = 16,
   parameter int IN_WIDTH   = 8,
   parameter int POOL_K     = 2,
   parameter int NUM_CH     = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             mode,
   pool_stream_gen_if.slave bus,
   output logic             busy,
   output logic             frame_done
);
   localparam int LOG_K     = $clog2(POOL_K);
   localparam int ACC_WIDTH = DATA_WIDTH + 2 * LOG_K;
   localparam int OUT_W     = IN_WIDTH / POOL_K;
   localparam int CW        = $clog2(IN_WIDTH);
   localparam int CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int JW        = CW - LOG_K;

   logic [CW-1:0]  col;
   logic [CW-1:0]  row;
   logic [CHW-1:0] ch;
   logic           mode_q;
   logic           out_valid_q;
   logic           out_last_q;
   logic [DATA_WIDTH-1:0] out_data_q;

   logic signed [ACC_WIDTH-1:0] h_acc;
   logic signed [ACC_WIDTH-1:0] line_buf [OUT_W];
   logic signed [ACC_WIDTH-1:0] pix;
   logic signed [ACC_WIDTH-1:0] h_new;
   logic signed [ACC_WIDTH-1:0] v_new;
   logic [JW-1:0]               j;
   logic [DATA_WIDTH-1:0]       pooled;

   logic accept, take, first_pix, last_pix, mode_eff;
   logic col_start, col_end_k, row_start, row_end_k, win_done;
   logic col_end, row_end, ch_end;

   function automatic logic signed [ACC_WIDTH-1:0] combine(
      input logic                        avg,
      input logic signed [ACC_WIDTH-1:0] a,
      input logic signed [ACC_WIDTH-1:0] b
   );
      return avg ? (a + b) : ((a > b) ? a : b);
   endfunction

   assign bus.in_ready  = !out_valid_q || bus.out_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;

   assign accept    = bus.in_valid && bus.in_ready;
   assign take      = out_valid_q && bus.out_ready;
   assign col_start = (col[LOG_K-1:0] == '0);
   assign col_end_k = (col[LOG_K-1:0] == '1);
   assign row_start = (row[LOG_K-1:0] == '0);
   assign row_end_k = (row[LOG_K-1:0] == '1);
   assign win_done  = col_end_k && row_end_k;
   assign col_end   = (col == CW'(IN_WIDTH - 1));
   assign row_end   = (row == CW'(IN_WIDTH - 1));
   assign ch_end    = (ch == CHW'(NUM_CH - 1));
   assign first_pix = (col == '0) && (row == '0) && (ch == '0);
   assign last_pix  = col_end && row_end && ch_end;
   assign mode_eff  = first_pix ? mode : mode_q;
   assign j         = col[CW-1:LOG_K];

   // The first pixel of each window row seeds the partial, so negative-only windows need no special seed.
   always_comb begin
      pix    = {{(2 * LOG_K){bus.in_data[DATA_WIDTH-1]}}, bus.in_data};
      h_new  = col_start ? pix : combine(mode_eff, h_acc, pix);
      v_new  = row_start ? h_new : combine(mode_eff, line_buf[j], h_new);
      pooled = mode_eff ? v_new[ACC_WIDTH-1:2*LOG_K] : v_new[DATA_WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col         <= '0;
         row         <= '0;
         ch          <= '0;
         h_acc       <= '0;
         mode_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
      end else if (clear) begin
         col         <= '0;
         row         <= '0;
         ch          <= '0;
         h_acc       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= take && out_last_q;
         if (take) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (out_last_q) busy <= 1'b0;
         end
         if (accept) begin
            h_acc <= h_new;
            // A new frame starting on the edge that retires out_last keeps busy high.
            if (first_pix) begin
               mode_q <= mode;
               busy   <= 1'b1;
            end
            if (win_done) begin
               out_valid_q <= 1'b1;
               out_data_q  <= pooled;
               out_last_q  <= last_pix;
            end
            if (col_end) begin
               col <= '0;
               if (row_end) begin
                  row <= '0;
                  ch  <= ch_end ? '0 : ch + 1'b1;
               end else begin
                  row <= row + 1'b1;
               end
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   // Stale entries after clear are harmless: window row 0 always overwrites.
   always_ff @(posedge clk) begin
      if (reset && !clear && accept && col_end_k && !row_end_k)
         line_buf[j] <= v_new;
   end
endmodule

// File: tb/tb_pool_stream_gen.sv
// Bench for pool_stream_gen: a 4x4 single-channel instance for directed windows,
// and an 8x8 four-channel instance for random back-to-back frames against a window model.
module tb_pool_stream_gen;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic s_clear = 1'b0, s_mode = 1'b0, s_busy, s_done;
   logic b_clear = 1'b0, b_mode = 1'b0, b_busy, b_done;
   int   cyc = 0;
   int   tests_run = 0;
   int   tests_failed = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pool_stream_gen_if #(.DATA_WIDTH(16)) sbus ();
   pool_stream_gen_if #(.DATA_WIDTH(16)) bbus ();

   pool_stream_gen #(.DATA_WIDTH(16), .IN_WIDTH(4), .POOL_K(2), .NUM_CH(1)) u_small (
      .clk(clk), .reset(rst_n), .clear(s_clear), .mode(s_mode),
      .bus(sbus), .busy(s_busy), .frame_done(s_done)
   );

   pool_stream_gen #(.DATA_WIDTH(16), .IN_WIDTH(8), .POOL_K(2), .NUM_CH(4)) u_big (
      .clk(clk), .reset(rst_n), .clear(b_clear), .mode(b_mode),
      .bus(bbus), .busy(b_busy), .frame_done(b_done)
   );

   // Output capture at the falling edge, where every input and output is settled.
   logic [15:0] s_got_q[$];
   logic        s_last_q[$];
   int          s_done_cyc[$];
   int          s_last_cyc = -10;
   logic [15:0] b_got_q[$];
   logic        b_last_q[$];
   int          b_done_n = 0;

   always @(negedge clk) begin
      if (sbus.out_valid && sbus.out_ready) begin
         s_got_q.push_back(sbus.out_data);
         s_last_q.push_back(sbus.out_last);
         if (sbus.out_last) s_last_cyc = cyc;
      end
      if (s_done) s_done_cyc.push_back(cyc);
      if (bbus.out_valid && bbus.out_ready) begin
         b_got_q.push_back(bbus.out_data);
         b_last_q.push_back(bbus.out_last);
      end
      if (b_done) b_done_n++;
   end

   task automatic clear_s_capture();
      s_got_q.delete();
      s_last_q.delete();
      s_done_cyc.delete();
      s_last_cyc = -10;
   endtask

   task automatic drive_s(input int v);
      int   n = 0;
      logic ok;
      sbus.in_valid = 1'b1;
      sbus.in_data  = 16'(v);
      do begin
         @(negedge clk);
         ok = sbus.in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!ok && n < 64);
      if (!ok) begin
         tests_run++;
         tests_failed++;
         $display("FAIL drive_s: in_ready stayed 0 for %0d cycles, required 1", n);
      end
      sbus.in_valid = 1'b0;
   endtask

   task automatic drive_b(input int v);
      int   n = 0;
      logic ok;
      bbus.in_valid = 1'b1;
      bbus.in_data  = 16'(v);
      do begin
         @(negedge clk);
         ok = bbus.in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!ok && n < 64);
      if (!ok) begin
         tests_run++;
         tests_failed++;
         $display("FAIL drive_b: in_ready stayed 0 for %0d cycles, required 1", n);
      end
      bbus.in_valid = 1'b0;
   endtask

   // mode is flipped right after the first pixel; the frame must keep its latched mode.
   task automatic send_s_frame(input int f[16], input logic m);
      s_mode = m;
      for (int i = 0; i < 16; i++) begin
         drive_s(f[i]);
         if (i == 0) s_mode = ~m;
      end
   endtask

   task automatic test_reset();
      tests_run++;
      if (sbus.out_valid !== 1'b0 || sbus.out_data !== 16'd0 || sbus.out_last !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_out: valid %b data %0d last %b, required 0 0 0",
                  sbus.out_valid, sbus.out_data, sbus.out_last);
      end
      tests_run++;
      if (s_busy !== 1'b0 || s_done !== 1'b0 || sbus.in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_ctl: busy %b frame_done %b in_ready %b, required 0 0 1",
                  s_busy, s_done, sbus.in_ready);
      end
      tests_run++;
      if (bbus.out_valid !== 1'b0 || b_busy !== 1'b0 || bbus.in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_big: valid %b busy %b in_ready %b, required 0 0 1",
                  bbus.out_valid, b_busy, bbus.in_ready);
      end
   endtask

   task automatic test_max();
      int f[16];
      int want[4] = '{5, 7, 13, 15};
      for (int i = 0; i < 16; i++) f[i] = i;
      clear_s_capture();
      sbus.out_ready = 1'b1;
      send_s_frame(f, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      tests_run++;
      if (s_got_q.size() != 4) begin
         tests_failed++;
         $display("FAIL max_count: got %0d results, required 4", s_got_q.size());
      end
      for (int i = 0; i < 4 && i < s_got_q.size(); i++) begin
         tests_run++;
         if (s_got_q[i] !== 16'(want[i]) || s_last_q[i] !== (i == 3)) begin
            tests_failed++;
            $display("FAIL max[%0d]: got %0d last %b, required %0d last %b",
                     i, $signed(s_got_q[i]), s_last_q[i], want[i], (i == 3));
         end
      end
      tests_run++;
      if (s_done_cyc.size() != 1 || s_done_cyc[0] != s_last_cyc + 1) begin
         tests_failed++;
         $display("FAIL max_frame_done: %0d pulses, first at cycle %0d, required 1 pulse at cycle %0d",
                  s_done_cyc.size(), (s_done_cyc.size() > 0) ? s_done_cyc[0] : -1, s_last_cyc + 1);
      end
      tests_run++;
      if (s_busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL max_busy_end: busy %b, required 0", s_busy);
      end
   endtask

   task automatic test_negative_max();
      int f[16] = '{-3, -8, -20, -30, -1, -5, -40, -25,
                    -100, -100, -2, -2, -100, -7, -2, -1};
      int want[4] = '{-1, -20, -7, -1};
      clear_s_capture();
      send_s_frame(f, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      tests_run++;
      if (s_got_q.size() != 4) begin
         tests_failed++;
         $display("FAIL negmax_count: got %0d results, required 4", s_got_q.size());
      end
      for (int i = 0; i < 4 && i < s_got_q.size(); i++) begin
         tests_run++;
         if (s_got_q[i] !== 16'(want[i])) begin
            tests_failed++;
            $display("FAIL negmax[%0d]: got %0d, required %0d", i, $signed(s_got_q[i]), want[i]);
         end
      end
   endtask

   task automatic test_average();
      int f[16] = '{1, 2, 4, 4, 3, -7, 4, 5,
                    -1, -1, 100, 101, -1, -2, 102, 103};
      int want[4] = '{-1, 4, -2, 101};
      clear_s_capture();
      send_s_frame(f, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      tests_run++;
      if (s_got_q.size() != 4) begin
         tests_failed++;
         $display("FAIL avg_count: got %0d results, required 4", s_got_q.size());
      end
      for (int i = 0; i < 4 && i < s_got_q.size(); i++) begin
         tests_run++;
         if (s_got_q[i] !== 16'(want[i]) || s_last_q[i] !== (i == 3)) begin
            tests_failed++;
            $display("FAIL avg[%0d]: got %0d last %b, required %0d last %b",
                     i, $signed(s_got_q[i]), s_last_q[i], want[i], (i == 3));
         end
      end
   endtask

   task automatic test_backpressure();
      int f[16];
      int want[4] = '{5, 7, 13, 15};
      for (int i = 0; i < 16; i++) f[i] = i;
      clear_s_capture();
      sbus.out_ready = 1'b0;
      fork
         send_s_frame(f, 1'b0);
         begin
            int n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!sbus.out_valid && n < 100);
            for (int i = 0; i < 5; i++) begin
               tests_run++;
               if (sbus.in_ready !== 1'b0 || sbus.out_valid !== 1'b1 || sbus.out_data !== 16'd5) begin
                  tests_failed++;
                  $display("FAIL stall[%0d]: in_ready %b valid %b data %0d, required 0 1 5",
                           i, sbus.in_ready, sbus.out_valid, sbus.out_data);
               end
               @(negedge clk);
            end
            @(posedge clk);
            #1;
            sbus.out_ready = 1'b1;
         end
      join
      repeat (4) @(posedge clk);
      #1;
      tests_run++;
      if (s_got_q.size() != 4) begin
         tests_failed++;
         $display("FAIL bp_count: got %0d results, required 4", s_got_q.size());
      end
      for (int i = 0; i < 4 && i < s_got_q.size(); i++) begin
         tests_run++;
         if (s_got_q[i] !== 16'(want[i]) || s_last_q[i] !== (i == 3)) begin
            tests_failed++;
            $display("FAIL bp[%0d]: got %0d last %b, required %0d last %b",
                     i, $signed(s_got_q[i]), s_last_q[i], want[i], (i == 3));
         end
      end
   endtask

   task automatic test_clear();
      int f[16];
      int want[4] = '{5, 7, 13, 15};
      for (int i = 0; i < 16; i++) f[i] = i;
      sbus.out_ready = 1'b1;
      s_mode = 1'b0;
      for (int i = 0; i < 10; i++) drive_s(100 + i);
      // The pixel offered alongside clear must be dropped.
      s_clear       = 1'b1;
      sbus.in_valid = 1'b1;
      sbus.in_data  = 16'd999;
      @(posedge clk);
      #1;
      s_clear       = 1'b0;
      sbus.in_valid = 1'b0;
      tests_run++;
      if (s_busy !== 1'b0 || sbus.out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL clear_state: busy %b valid %b, required 0 0", s_busy, sbus.out_valid);
      end
      clear_s_capture();
      send_s_frame(f, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      tests_run++;
      if (s_got_q.size() != 4) begin
         tests_failed++;
         $display("FAIL clear_count: got %0d results, required 4", s_got_q.size());
      end
      for (int i = 0; i < 4 && i < s_got_q.size(); i++) begin
         tests_run++;
         if (s_got_q[i] !== 16'(want[i])) begin
            tests_failed++;
            $display("FAIL clear[%0d]: got %0d, required %0d", i, $signed(s_got_q[i]), want[i]);
         end
      end
   endtask

   task automatic test_multi_channel();
      int          pix[512];
      logic [15:0] exp_q[$];
      logic        exp_last_q[$];
      int          mx, sum, v;
      for (int i = 0; i < 512; i++) pix[i] = int'($urandom_range(0, 65535)) - 32768;
      // Frame 0 latches max, frame 1 latches average.
      for (int fr = 0; fr < 2; fr++)
         for (int c = 0; c < 4; c++)
            for (int wr = 0; wr < 4; wr++)
               for (int wc = 0; wc < 4; wc++) begin
                  mx  = -100000;
                  sum = 0;
                  for (int dr = 0; dr < 2; dr++)
                     for (int dc = 0; dc < 2; dc++) begin
                        v   = pix[fr * 256 + c * 64 + (wr * 2 + dr) * 8 + wc * 2 + dc];
                        sum = sum + v;
                        if (v > mx) mx = v;
                     end
                  exp_q.push_back(16'((fr == 1) ? (sum >>> 2) : mx));
                  exp_last_q.push_back(c == 3 && wr == 3 && wc == 3);
               end
      b_got_q.delete();
      b_last_q.delete();
      b_done_n = 0;
      fork
         for (int p = 0; p < 512; p++) begin
            if (p == 0)   b_mode = 1'b0;
            if (p == 100) b_mode = 1'b1;
            if (p == 356) b_mode = 1'b0;
            if (p != 256)
               while ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
            drive_b(pix[p]);
         end
         begin
            int n = 0;
            while (b_got_q.size() < 128 && n < 8000) begin
               @(posedge clk);
               #1;
               bbus.out_ready = ($urandom_range(0, 3) != 0);
               n++;
            end
            bbus.out_ready = 1'b1;
         end
      join
      repeat (4) @(posedge clk);
      #1;
      tests_run++;
      if (b_got_q.size() != 128) begin
         tests_failed++;
         $display("FAIL multi_count: got %0d results, required 128", b_got_q.size());
      end
      for (int i = 0; i < 128 && i < b_got_q.size(); i++) begin
         tests_run++;
         if (b_got_q[i] !== exp_q[i] || b_last_q[i] !== exp_last_q[i]) begin
            tests_failed++;
            $display("FAIL multi[%0d]: got %0d last %b, required %0d last %b",
                     i, $signed(b_got_q[i]), b_last_q[i], $signed(exp_q[i]), exp_last_q[i]);
         end
      end
      tests_run++;
      if (b_done_n != 2 || b_busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL multi_done: frame_done pulses %0d busy %b, required 2 0", b_done_n, b_busy);
      end
   endtask

   task automatic test_reset_mid_frame();
      int f[16];
      int want[4] = '{5, 7, 13, 15};
      for (int i = 0; i < 16; i++) f[i] = i;
      sbus.out_ready = 1'b0;
      s_mode = 1'b0;
      for (int i = 0; i < 6; i++) drive_s(i);
      tests_run++;
      if (sbus.out_valid !== 1'b1 || s_busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL pre_reset: valid %b busy %b, required 1 1", sbus.out_valid, s_busy);
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (sbus.out_valid !== 1'b0 || sbus.out_data !== 16'd0 || sbus.out_last !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_reset_out: valid %b data %0d last %b, required 0 0 0",
                  sbus.out_valid, sbus.out_data, sbus.out_last);
      end
      tests_run++;
      if (s_busy !== 1'b0 || s_done !== 1'b0 || sbus.in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL async_reset_ctl: busy %b frame_done %b in_ready %b, required 0 0 1",
                  s_busy, s_done, sbus.in_ready);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      sbus.out_ready = 1'b1;
      clear_s_capture();
      send_s_frame(f, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      tests_run++;
      if (s_got_q.size() != 4) begin
         tests_failed++;
         $display("FAIL restart_count: got %0d results, required 4", s_got_q.size());
      end
      for (int i = 0; i < 4 && i < s_got_q.size(); i++) begin
         tests_run++;
         if (s_got_q[i] !== 16'(want[i]) || s_last_q[i] !== (i == 3)) begin
            tests_failed++;
            $display("FAIL restart[%0d]: got %0d last %b, required %0d last %b",
                     i, $signed(s_got_q[i]), s_last_q[i], want[i], (i == 3));
         end
      end
   endtask

   initial begin
      sbus.in_valid  = 1'b0;
      sbus.in_data   = '0;
      sbus.out_ready = 1'b0;
      bbus.in_valid  = 1'b0;
      bbus.in_data   = '0;
      bbus.out_ready = 1'b0;
      rst_n = 1'b0;
      #12;
      test_reset();
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      test_max();
      test_negative_max();
      test_average();
      test_backpressure();
      test_clear();
      test_multi_channel();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded 50000 cycles, required completion");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/pool_stream_gen.md
# pool_stream_gen

Parametrised streaming pooling stage that sits between a convolution engine and the next layer's feature-map RAM. It generalises the fixed 2×2 max-pool stage to a configurable window size, channel count and data width, adds a run-time average mode and a valid/ready handshake on both sides, and keeps row partials in an internal line buffer. It reduces each K×K non-overlapping window of every channel to one output word.

## Interface
- DATA_WIDTH, 16, signed two's-complement pixel width (in and out)
- IN_WIDTH, 8, input feature-map width = height; must be a multiple of POOL_K
- POOL_K, 2, window size = stride; legal values 2 or 4
- NUM_CH, 4, feature maps per frame, sent channel-major
- ACC_WIDTH, DATA_WIDTH+2*log2(POOL_K), internal sum width (derived localparam)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- clear  in  1  synchronous abort: drops the frame in progress
- mode  in  1  0 = max, 1 = average; sampled on the first accepted pixel of each frame
- in_valid  in  1  input pixel valid
- in_ready  out  1  block accepts input pixel
- in_data  in  DATA_WIDTH  input pixel, raster order per channel
- out_valid  out  1  pooled result valid
- out_ready  in  1  downstream accepts result
- out_data  out  DATA_WIDTH  pooled result
- out_last  out  1  marks the final result of a frame (with out_valid)
- busy  out  1  frame in progress (first pixel accepted, last result not yet accepted)
- frame_done  out  1  one-cycle pulse when the out_last result is accepted

## Operation
- Transfer occurs when valid && ready on the same edge.
- Counters:
  - col: 0..IN_WIDTH-1.
  - row: 0..IN_WIDTH-1.
  - ch: 0..NUM_CH-1.
  - Nesting is col → row → ch. All wrap to 0 after the final pixel of the frame.
- OUT_W = IN_WIDTH/POOL_K. The line buffer holds OUT_W entries of ACC_WIDTH; index j = col/POOL_K.
- Horizontal partial h_acc:
  - Loaded with the pixel when col%K==0.
  - Otherwise combined with it: max uses a signed compare; avg uses a sign-extended add.
- At col%K==K-1, the combined h value goes to line-buffer entry j:
  - If row%K==0, entry j is overwritten.
  - Otherwise, entry j is combined with the h value.
- Window-complete pixel (row%K==K-1 and col%K==K-1) loads the output register instead:
  - max: the final max.
  - avg: sum >>> (2*log2 K), an arithmetic shift, so rounding is toward −∞. The result is then truncated to DATA_WIDTH.
- No zero-initialisation of the max path: the first pixel of each window seeds it, so all-negative windows pool correctly.
- out_last = 1 for the result of ch=NUM_CH-1, last window row, last window column.
- Outputs per frame: NUM_CH·OUT_W² in order ch, window row, window col.
- Mode is latched at the first pixel (col=row=ch=0). Changes on `mode` mid-frame are ignored until the next frame.
- clear:
  - Resets counters, h_acc, out_valid, out_last and busy on the next edge.
  - A pixel presented in the same cycle is dropped.
  - clear takes priority over all other events.
  - Line-buffer contents need not be cleared; they are overwritten because row%K==0 overwrites.

## Timing
- in_ready = !out_valid || out_ready, combinational. After reset it is 1.
- Throughput: 1 pixel/cycle while out_ready is held high. No bubbles at row, channel or frame boundaries.
- Latency: out_valid rises on the edge that accepts the window-completing pixel, so the result is visible the next cycle.
- out_data and out_last are held stable while out_valid && !out_ready.
- Output accepted and a new completing pixel accepted on the same edge: the output register reloads and out_valid stays 1.
- busy:
  - Rises on the edge accepting the first pixel.
  - Falls on the edge accepting the out_last result.
  - frame_done pulses high during the cycle after that edge.
- Back-to-back frames: the first pixel of the next frame may be accepted on the same edge as the out_last result. busy then stays 1.
- Reset values (reset=0, async): out_valid 0, out_data 0, out_last 0, busy 0, frame_done 0, all counters 0, latched mode 0. in_ready is 1 once reset is applied.
- Reset released mid-frame: the block restarts at pixel (0,0,0).

## Test plan
- Max mode:
  - Stimulus: IN_WIDTH=4, K=2, NUM_CH=1, out_ready=1, pixels 0..15 raster.
  - Required: outputs 5, 7, 13, 15; out_last only on 15; frame_done one cycle later.
- Negative max:
  - Stimulus: window {-3, -8, -1, -5}.
  - Required: output -1, not 0.
- Average mode:
  - Stimulus: windows {1, 2, 3, -7} and {4, 4, 4, 5}.
  - Required: outputs -1 (sum -1 >>> 2) and 4 (17 >>> 2).
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles while a result is pending.
  - Required: in_ready=0 during the stall; out_data held; no pixel lost; the full output sequence matches the max-mode case.
- Multi-channel frame:
  - Stimulus: NUM_CH=4, IN_WIDTH=8, random data, random valid/ready, two back-to-back frames with mode toggled mid-frame.
  - Required: 64 results per frame matching the model; mode takes effect only on the next frame.
- Abort and reset:
  - Stimulus: clear asserted after 10 pixels, then a full frame.
  - Required: that frame's results are correct.
  - Stimulus: reset=0 asserted mid-frame.
  - Required: all outputs return to reset values asynchronously.
